uart_tx: RTL and testbench
==========================

Name: uart_tx

Overview:
- 8-N-1 UART transmitter; the transmit counterpart to the team's UART receiver on the same serial link.
- Accepts one byte per valid/ready handshake from the core logic and serializes it LSB-first onto the tx line.
- Bit timing comes from an internal clock-enable divider on the system clock. It uses no derived clock, so all logic runs on clk.
- Sits between the command/loopback logic and the board TX pin.

Parameters:
- CLK_FREQ, 100000000, system clock frequency in Hz.
- BAUD, 9600, line rate in bits/s.
- CLKS_PER_BIT, CLK_FREQ/BAUD (integer truncation, 10416 at defaults), clk cycles per bit. Derived; do not override directly.
- STOP_BITS, 1, number of stop bits; legal values 1 or 2.
- PARITY_ODD, 0, parity sense when UART_TX_PARITY_EN is defined (0 = even, 1 = odd). Ignored otherwise.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst  input  1  asynchronous, active-low reset (asserted when 0).
- tx_valid  input  1  byte in tx_data is offered for transmission.
- tx_data  input  8  byte to send; sampled only at handshake.
- tx_ready  output  1  transmitter can accept a byte this cycle.
- tx  output  1  serial line, idle high.
- busy  output  1  a frame is in progress (START through end of STOP).
- done  output  1  one-cycle pulse at completion of each frame.

Behaviour:
- Reset (rst=0, asynchronous): tx=1, tx_ready=0, busy=0, done=0, state=IDLE, bit counter=0, baud counter=0, shift register=8'h00. tx must go high immediately, including mid-frame.
- First clk edge after rst deasserts: tx_ready=1.
- States: IDLE, START, DATA, STOP (plus PARITY under the macro).
- IDLE:
  - tx=1, busy=0, tx_ready=1.
  - On tx_valid && tx_ready: latch tx_data into the shift register, clear the baud counter, go to START, tx_ready=0.
  - tx_valid low: remain in IDLE.
- START:
  - tx=0 for exactly CLKS_PER_BIT cycles, starting the cycle after the handshake. Handshake-to-tx-low latency is 1 clk.
  - Then go to DATA with bit counter=0.
- DATA:
  - tx=shift[0] for CLKS_PER_BIT cycles per bit, then shift right and increment the bit counter.
  - After bit 7 completes: go to STOP, or to PARITY under the macro.
- STOP:
  - tx=1 for STOP_BITS*CLKS_PER_BIT cycles.
  - On the final cycle: done=1 for exactly one clk, then IDLE.
- busy=1 from the first START cycle through the last STOP cycle inclusive.
- Frame length is (10 + STOP_BITS - 1)*CLKS_PER_BIT clk, plus CLKS_PER_BIT with parity.
- Baud counter width is clog2(CLKS_PER_BIT). It counts 0..CLKS_PER_BIT-1, then wraps to 0 and advances the bit position. No drift across a frame.
- Changes on tx_data or tx_valid while tx_ready=0 are ignored. The latched byte is unaffected.
- Back-to-back: tx_valid held high is accepted on the first IDLE cycle after done. Inter-frame idle gap is exactly 1 clk of tx=1, beyond the stop bit(s).
- Reset asserted mid-frame: frame is abandoned, no done pulse, and the byte is not resumed after release.
- tx is registered (glitch-free). No combinational path from inputs to tx.

Optional Feature:
- Macro: UART_TX_PARITY_EN.
- Defined: a PARITY state is inserted between DATA and STOP.
  - tx = ^latched_byte (even) or ~^latched_byte (odd, PARITY_ODD=1) for CLKS_PER_BIT cycles.
  - Parity is computed from the byte latched at handshake.
- Not defined: no PARITY state, no parity logic, frame is 8-N-STOP_BITS, and PARITY_ODD is unused.

Test Plan:
- Bench configuration for all scenarios: CLK_FREQ=16, BAUD=1 (CLKS_PER_BIT=16), STOP_BITS=1.
- Send 8'hA5 with one-cycle tx_valid:
  - tx low 1 clk after handshake for 16 clk.
  - Then bits 1,0,1,0,0,1,0,1 at 16 clk each.
  - Then high 16 clk, done pulses once at clk 160 of the frame, busy high for 160 clk.
- tx_valid held high with 8'h00 then 8'hFF:
  - Two frames separated by exactly 1 idle clk.
  - Second frame data bits all 1.
  - tx_data changes during frame 1 have no effect.
- rst pulled low at data bit 3 of 8'h3C:
  - tx=1 within the same cycle (async), no done pulse, tx_ready=0 during reset, tx_ready=1 one clk after release.
  - Next handshake sends a clean full frame.
- STOP_BITS=2, send 8'h81: stop high for 32 clk, total frame 176 clk, done at frame end.
- UART_TX_PARITY_EN defined, PARITY_ODD=0:
  - 8'h07 gives parity bit 1; 8'h03 gives parity bit 0.
  - With PARITY_ODD=1, 8'h03 gives 1.
  - Frame length 176 clk.
- Loopback: tx wired to the team's UART receiver at matching BAUD, send 8'h55, 8'hAA, 8'h0F. Receiver reports identical bytes in order.

Source files
------------

// File: rtl/uart_tx.sv
// uart_tx: 8-N-1 UART transmitter with a valid/ready byte interface.
// Bit timing comes from a clock-enable counter on clk, so there is no derived clock.
// Optional feature: define UART_TX_PARITY_EN to insert a parity bit between the
// data bits and the stop bit(s). PARITY_ODD selects the parity sense.
module uart_tx #(
    parameter int CLK_FREQ   = 100000000,
    parameter int BAUD       = 9600,
    parameter int STOP_BITS  = 1,
    parameter int PARITY_ODD = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tx_valid,
    input  logic [7:0] tx_data,
    output logic       tx_ready,
    output logic       tx,
    output logic       busy,
    output logic       done
);

    // Derived bit period; not a parameter so it cannot be overridden.
    localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
    localparam int CW           = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
    // done is registered, so it is armed one cycle before the last stop cycle.
    localparam logic [CW-1:0] CNT_PRE  = CW'(CLKS_PER_BIT - 2);

    // An illegal configuration falls back to a single stop bit.
    localparam bit CFG_OK = ((STOP_BITS == 1) || (STOP_BITS == 2)) &&
                            ((PARITY_ODD == 0) || (PARITY_ODD == 1));
    localparam logic [2:0] STOP_LAST = (CFG_OK && (STOP_BITS == 2)) ? 3'd1 : 3'd0;

`ifdef UART_TX_PARITY_EN
    localparam logic PAR_SENSE = (PARITY_ODD != 0);
`endif

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        STOP   = 3'd3
`ifdef UART_TX_PARITY_EN
        ,
        PARITY = 3'd4
`endif
    } state_e;

    state_e        state_q;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          cnt_wrap;
    logic [2:0]    bit_q;
    logic [7:0]    shift_q;
    logic          tx_q;
    logic          busy_q;
    logic          done_q;
    logic          ready_q;
`ifdef UART_TX_PARITY_EN
    logic          par_q;
`endif

    // Baud counter: free-runs 0..CLKS_PER_BIT-1; a wrap marks the end of a bit slot.
    always_comb begin
        cnt_wrap = (cnt_q == CNT_LAST);
        cnt_d    = cnt_wrap ? '0 : cnt_q + CW'(1);
    end

    // Frame sequencer with registered line and status outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= 8'h00;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            ready_q <= 1'b0;
`ifdef UART_TX_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            cnt_q  <= cnt_d;
            case (state_q)
                IDLE: begin
                    cnt_q   <= '0;
                    tx_q    <= 1'b1;
                    busy_q  <= 1'b0;
                    ready_q <= 1'b1;
                    if (tx_valid && ready_q) begin
                        shift_q <= tx_data;
                        state_q <= START;
                        tx_q    <= 1'b0;
                        busy_q  <= 1'b1;
                        ready_q <= 1'b0;
`ifdef UART_TX_PARITY_EN
                        par_q   <= (^tx_data) ^ PAR_SENSE;
`endif
                    end
                end
                START: begin
                    if (cnt_wrap) begin
                        state_q <= DATA;
                        bit_q   <= '0;
                        tx_q    <= shift_q[0];
                    end
                end
                DATA: begin
                    if (cnt_wrap) begin
                        if (bit_q == 3'd7) begin
                            bit_q <= '0;
`ifdef UART_TX_PARITY_EN
                            state_q <= PARITY;
                            tx_q    <= par_q;
`else
                            state_q <= STOP;
                            tx_q    <= 1'b1;
`endif
                        end else begin
                            shift_q <= {1'b0, shift_q[7:1]};
                            bit_q   <= bit_q + 3'd1;
                            tx_q    <= shift_q[1];
                        end
                    end
                end
`ifdef UART_TX_PARITY_EN
                PARITY: begin
                    if (cnt_wrap) begin
                        state_q <= STOP;
                        bit_q   <= '0;
                        tx_q    <= 1'b1;
                    end
                end
`endif
                STOP: begin
                    if ((bit_q == STOP_LAST) && (cnt_q == CNT_PRE)) begin
                        done_q <= 1'b1;
                    end
                    if (cnt_wrap) begin
                        if (bit_q == STOP_LAST) begin
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
                            ready_q <= 1'b1;
                        end else begin
                            bit_q <= bit_q + 3'd1;
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                    tx_q    <= 1'b1;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign tx       = tx_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign tx_ready = ready_q;

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: scoreboard bench for uart_tx. Stimulus pushes expected bytes; a
// serial-line decoder on DUT0 pops and compares. A per-cycle frame check verifies
// line waveform, busy, done position and ready against the frame timeline.
module tb_uart_tx;

    localparam int CPB = 16;
`ifdef UART_TX_PARITY_EN
    localparam int PB = 1;
`else
    localparam int PB = 0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       vld0 = 1'b0, vld1 = 1'b0;
    logic [7:0] dat0 = 8'h00, dat1 = 8'h00;
    logic       rdy0, tx0, busy0, done0;
    logic       rdy1, tx1, busy1, done1;
    logic       sel = 1'b0;
    logic       tx_s, rdy_s, busy_s, done_s;

    int         n_tests = 0;
    int         n_fail = 0;
    int         ndone0 = 0;
    int         exp_done0 = 0;
    logic [7:0] sb[$];

    always #5 clk = ~clk;

    // DUT0: one stop bit, even parity when enabled.
    uart_tx #(.CLK_FREQ(16), .BAUD(1), .STOP_BITS(1), .PARITY_ODD(0)) u_dut0 (
        .clk(clk), .rst(rst), .tx_valid(vld0), .tx_data(dat0),
        .tx_ready(rdy0), .tx(tx0), .busy(busy0), .done(done0)
    );

    // DUT1: two stop bits, odd parity when enabled.
    uart_tx #(.CLK_FREQ(16), .BAUD(1), .STOP_BITS(2), .PARITY_ODD(1)) u_dut1 (
        .clk(clk), .rst(rst), .tx_valid(vld1), .tx_data(dat1),
        .tx_ready(rdy1), .tx(tx1), .busy(busy1), .done(done1)
    );

    assign tx_s   = sel ? tx1   : tx0;
    assign rdy_s  = sel ? rdy1  : rdy0;
    assign busy_s = sel ? busy1 : busy0;
    assign done_s = sel ? done1 : done0;

    always @(negedge clk) if (done0 === 1'b1) ndone0++;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic exp_tx(input logic [7:0] b, input int i, input logic par);
        int k;
        k = (i - 1) / CPB;
        if (k == 0) return 1'b0;
        if (k <= 8) return b[k-1];
        if ((PB == 1) && (k == 9)) return par;
        return 1'b1;
    endfunction

    // Handshake one byte on the selected DUT; returns at frame cycle 1.
    task automatic hs(input logic [7:0] b, input logic keep, input logic [7:0] nxt, input logic push);
        int w;
        w = 0;
        while (rdy_s !== 1'b1 && w < 400) begin
            @(negedge clk);
            w++;
        end
        chk("rdy_wait", 32'(rdy_s), 32'd1);
        chk("pre_hs_tx", 32'(tx_s), 32'd1);
        if (sel) begin vld1 = 1'b1; dat1 = b; end
        else     begin vld0 = 1'b1; dat0 = b; end
        if (push) sb.push_back(b);
        @(negedge clk);
        if (!keep) begin vld0 = 1'b0; vld1 = 1'b0; end
        if (sel) dat1 = nxt; else dat0 = nxt;
    endtask

    // Check every cycle of a frame, then the following idle cycle.
    task automatic run_frame(input logic [7:0] b, input string tag);
        int   nsb, fl, btx, bbusy, brdy, ndn, dpos;
        logic par;
        nsb = sel ? 2 : 1;
        fl  = (9 + nsb + PB) * CPB;
        par = (^b) ^ sel;
        btx = 0; bbusy = 0; brdy = 0; ndn = 0; dpos = 0;
        for (int i = 1; i <= fl; i++) begin
            if (i > 1) @(negedge clk);
            if (tx_s !== exp_tx(b, i, par)) btx++;
            if (busy_s !== 1'b1) bbusy++;
            if (rdy_s !== 1'b0) brdy++;
            if (done_s === 1'b1) begin ndn++; dpos = i; end
        end
        chk({tag, "_tx_bad_cycles"}, 32'(btx), 32'd0);
        chk({tag, "_busy_bad_cycles"}, 32'(bbusy), 32'd0);
        chk({tag, "_rdy_bad_cycles"}, 32'(brdy), 32'd0);
        chk({tag, "_done_count"}, 32'(ndn), 32'd1);
        chk({tag, "_done_pos"}, 32'(dpos), 32'(fl));
        @(negedge clk);
        chk({tag, "_idle_tx"}, 32'(tx_s), 32'd1);
        chk({tag, "_idle_busy"}, 32'(busy_s), 32'd0);
        chk({tag, "_idle_done"}, 32'(done_s), 32'd0);
        chk({tag, "_idle_rdy"}, 32'(rdy_s), 32'd1);
        if (!sel) exp_done0++;
    endtask

    // Wait n negedges for the decoder; give up as soon as reset is seen.
    task automatic mwait(input int n, inout logic ok);
        for (int i = 0; i < n; i++) begin
            if (!ok) return;
            @(negedge clk);
            if (!rst) ok = 1'b0;
        end
    endtask

    // Serial decoder on DUT0 acting as the receiving end of the link.
    initial begin : mon
        logic       prev, ok, pb;
        logic [7:0] got, e;
        prev = 1'b1;
        forever begin
            @(negedge clk);
            if (rst && prev && (tx0 === 1'b0)) begin
                ok = 1'b1; got = 8'h00; pb = 1'b0;
                mwait(CPB/2 - 1, ok);
                if (ok) chk("mon_start", 32'(tx0), 32'd0);
                for (int j = 0; j < 8; j++) begin
                    mwait(CPB, ok);
                    got[j] = tx0;
                end
`ifdef UART_TX_PARITY_EN
                mwait(CPB, ok);
                pb = tx0;
`endif
                mwait(CPB, ok);
                if (ok) begin
                    chk("mon_stop", 32'(tx0), 32'd1);
                    chk("mon_sb_avail", 32'(sb.size() > 0), 32'd1);
                    if (sb.size() > 0) begin
                        e = sb.pop_front();
                        chk("mon_byte", 32'(got), 32'(e));
`ifdef UART_TX_PARITY_EN
                        chk("mon_par", 32'(pb), 32'(^e));
`endif
                    end
                end
            end
            prev = tx0;
        end
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
        $fatal(1, "timeout");
    end

    initial begin : stim
        int n, bad;
        // Reset state
        #2 rst = 1'b0;
        #1;
        chk("rst_tx0", 32'(tx0), 32'd1);
        chk("rst_rdy0", 32'(rdy0), 32'd0);
        chk("rst_busy0", 32'(busy0), 32'd0);
        chk("rst_done0", 32'(done0), 32'd0);
        chk("rst_tx1", 32'(tx1), 32'd1);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("rdy_after_rst", 32'(rdy0), 32'd1);

        // Single frame, data input changes after handshake
        hs(8'hA5, 1'b0, 8'h5A, 1'b1);
        run_frame(8'hA5, "a5");

        // Back-to-back with tx_valid held high
        hs(8'h00, 1'b1, 8'hFF, 1'b1);
        sb.push_back(8'hFF);
        run_frame(8'h00, "b2b0");
        @(negedge clk);
        vld0 = 1'b0;
        dat0 = 8'h12;
        run_frame(8'hFF, "b2b1");

        // Reset in the middle of data bit 3
        hs(8'h3C, 1'b0, 8'h00, 1'b0);
        repeat (69) @(negedge clk);
        chk("pre_rst_busy", 32'(busy0), 32'd1);
        n = ndone0;
        #2 rst = 1'b0;
        #1;
        chk("midrst_tx", 32'(tx0), 32'd1);
        chk("midrst_busy", 32'(busy0), 32'd0);
        chk("midrst_rdy", 32'(rdy0), 32'd0);
        repeat (3) @(negedge clk);
        chk("inrst_rdy", 32'(rdy0), 32'd0);
        rst = 1'b1;
        @(negedge clk);
        chk("rel_rdy", 32'(rdy0), 32'd1);
        bad = 0;
        for (int i = 0; i < 40; i++) begin
            if (tx0 !== 1'b1 || busy0 !== 1'b0) bad++;
            @(negedge clk);
        end
        chk("no_resume", 32'(bad), 32'd0);
        chk("no_done_abort", 32'(ndone0 - n), 32'd0);
        hs(8'h3C, 1'b0, 8'hC3, 1'b1);
        run_frame(8'h3C, "3c");

        // Loopback byte stream
        hs(8'h55, 1'b0, 8'h00, 1'b1);
        run_frame(8'h55, "lb55");
        hs(8'hAA, 1'b0, 8'h00, 1'b1);
        run_frame(8'hAA, "lbaa");
        hs(8'h0F, 1'b0, 8'h00, 1'b1);
        run_frame(8'h0F, "lb0f");

`ifdef UART_TX_PARITY_EN
        hs(8'h07, 1'b0, 8'h00, 1'b1);
        run_frame(8'h07, "par07");
        hs(8'h03, 1'b0, 8'h00, 1'b1);
        run_frame(8'h03, "par03");
`endif

        // Two stop bits on DUT1
        sel = 1'b1;
        @(negedge clk);
        hs(8'h81, 1'b0, 8'h7E, 1'b0);
        run_frame(8'h81, "s2_81");
`ifdef UART_TX_PARITY_EN
        hs(8'h03, 1'b0, 8'h00, 1'b0);
        run_frame(8'h03, "odd03");
`endif
        sel = 1'b0;

        repeat (4) @(negedge clk);
        chk("sb_drained", 32'(sb.size()), 32'd0);
        chk("done_total0", 32'(ndone0), 32'(exp_done0));
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
